axis_i2c_slave: RTL and testbench
=================================

Name: axis_i2c_slave

Overview:
- I2C responder (target) that closes the loop with the team's AXI-Stream I2C master.
- Bytes written by an external I2C master leave on an AXI-Stream master port.
- Bytes the external master reads are taken from an AXI-Stream slave port.
- Sits on the board-side I2C bus or in loopback against axis_i2c_top in system benches.
- Oversamples SCL/SDA on the single system clock. No clock stretching.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address this block answers to.
- SYNC_STAGES, 2, flip-flop stages on the SCL and SDA inputs (≥2).

Ports:
- clk_i  input  1  system clock
- arstn_i  input  1  reset, synchronous, active-low
- i2c_scl_i  input  1  I2C clock from the bus
- i2c_sda_io  inout  1  I2C data. Open-drain: driven 0 or high-Z, never driven 1.
- m_axis_tdata  output  8  byte received in a write transfer
- m_axis_tvalid  output  1  m_axis data valid
- m_axis_tready  input  1  downstream accept
- m_axis_tlast  output  1  reserved, always 0
- s_axis_tdata  input  8  byte to return in a read transfer
- s_axis_tvalid  input  1  read data available
- s_axis_tready  output  1  one-cycle pulse when a read byte is loaded
- busy_o  output  1  high from a detected START until the detected STOP
- ovf_o  output  1  one-cycle pulse when a write byte is NACKed because the m_axis holding register is still full
- unf_o  output  1  one-cycle pulse when a read byte is needed and s_axis_tvalid=0

Behaviour:
- Reset (arstn_i=0 sampled on clk_i rising edge):
  - state=IDLE, SDA released (high-Z).
  - m_axis_tvalid, m_axis_tdata, s_axis_tready, busy_o, ovf_o, unf_o all 0.
  - Sync flops preset to 1 (bus idle).
  - Reset mid-transfer releases SDA in the next cycle; the bus transaction is abandoned.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops plus one delay flop for edge detection.
  - All conditions below use the synchronized signals.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Both are honoured in every state. START (including repeated START) → ADDR, bit counter cleared, busy_o=1. STOP → IDLE, busy_o=0, SDA released.
- Sampling and driving rules:
  - SDA is sampled on SCL rise, MSB first.
  - SDA output changes only on the cycle after an SCL fall is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W). On the 8th SCL rise:
    - If the address matches I2C_ADDR → ADDR_ACK.
    - Otherwise → WAIT_STOP (SDA never driven).
  - ADDR_ACK: drive SDA=0 from the next SCL fall to the following SCL fall.
    - If W=0 → WR_DATA.
    - If R=1: at that ACK-entering SCL fall, load shift register from s_axis_tdata and pulse s_axis_tready if s_axis_tvalid=1. Otherwise load 8'hFF and pulse unf_o. → RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th SCL rise:
    - If m_axis_tvalid=0 or (m_axis_tvalid & m_axis_tready) in the same cycle: register the byte; m_axis_tvalid=1 the next cycle; ACK.
    - Otherwise drop the byte, pulse ovf_o, NACK (SDA released).
    - → WR_ACK.
  - WR_ACK: ACK or NACK held for one SCL period, then → WR_DATA.
  - RD_DATA: drive the shift-register MSB after each SCL fall (0 → drive low, 1 → release). After the 8th bit's SCL fall, release SDA → RD_ACK.
  - RD_ACK: sample master ACK on SCL rise.
    - ACK (0): load the next byte at the following SCL fall, using the same s_axis/unf rules → RD_DATA.
    - NACK (1): → WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on START or STOP.
- m_axis_tvalid stays high until the handshake, independent of bus state.
- m_axis latency: m_axis_tvalid rises 1 clk_i after the synchronized 8th SCL rise of a data byte.

Decomposition:
- Package axis_i2c_pkg holds:
  - state enum typedef i2c_slv_state_e
  - I2C_RW_READ/I2C_RW_WRITE constants
  - ACK/NACK constants
- One sub-module: i2c_bus_sync. Synchronizer plus edge detector; outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write 0xA0 (addr 0x50, W), data 0x3C, 0xC3, STOP, m_axis_tready=1 → ACK on all 3 bytes; m_axis emits 0x3C then 0xC3; busy_o falls after STOP.
- Address 0x51 write → no ACK (SDA high on 9th clock); no m_axis activity; block ignores bus until STOP.
- Read 0xA1 with s_axis bytes 0x5A, 0x99; master ACKs then NACKs → bus carries 0x5A, 0x99; s_axis_tready pulses twice; state returns to IDLE on STOP.
- Read with s_axis_tvalid=0 → bus carries 0xFF; unf_o pulses once.
- Write 3 bytes 0x01, 0x02, 0x03 with m_axis_tready=0 → 0x01 ACKed and held; 0x02 and 0x03 NACKed; ovf_o pulses twice; m_axis_tdata stays 0x01.
- Write 0xA0, 0x11, repeated START, 0xA1 read → 0x11 on m_axis, then read phase served. Separately, arstn_i low mid-read → SDA released the next cycle; state=IDLE.

Source files
------------

// File: rtl/axis_i2c_pkg.sv
// Shared types and bus constants for the AXI-Stream I2C target.
package axis_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_slv_state_e;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and START/STOP/edge detector; events lag the pins by SYNC_STAGES+1 clk_i.
// No backpressure: every output event is a single-cycle pulse.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Preset to 1 so a reset never fabricates a START or STOP on an idle bus.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_rise_o  = scl_s & ~scl_dly_q;
  assign scl_fall_o  = ~scl_s & scl_dly_q;
  assign start_det_o = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign sda_s_o     = sda_s;

endmodule

// File: rtl/axis_i2c_slave.sv
// I2C target bridging bus writes to m_axis and bus reads from s_axis; m_axis_tvalid rises 1 clk after the 8th SCL rise.
// A full m_axis register NACKs the byte (ovf_o); an empty s_axis returns 8'hFF (unf_o). No clock stretching.
module axis_i2c_slave
  import axis_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       i2c_scl_i,
  inout  wire        i2c_sda_io,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       unf_o
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .scl_i       (i2c_scl_i),
    .sda_i       (i2c_sda_io),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_s_o     (sda_s)
  );

  i2c_slv_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] m_tdata_q, m_tdata_d;
  logic       sda_oe_q, sda_oe_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       m_tvalid_q, m_tvalid_d;
  logic       s_tready_q, s_tready_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       busy_q, busy_d;
  logic       rd_load;
  logic [7:0] byte_in;
  logic       sda_drv_low;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      m_tdata_q  <= '0;
      sda_oe_q   <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= I2C_RW_WRITE;
      ack_q      <= I2C_NACK;
      m_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      m_tdata_q  <= m_tdata_d;
      sda_oe_q   <= sda_oe_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      m_tvalid_q <= m_tvalid_d;
      s_tready_q <= s_tready_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      busy_q     <= busy_d;
    end
  end

  // phase_q marks the second half of a two-fall ACK slot (or a pending master ACK in RD_ACK).
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    m_tdata_d  = m_tdata_q;
    sda_oe_d   = sda_oe_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    m_tvalid_d = m_tvalid_q & ~m_axis_tready;
    s_tready_d = 1'b0;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    busy_d     = busy_q;
    rd_load    = 1'b0;
    byte_in    = {shift_q[6:0], sda_s};

    if (stop_det) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = byte_in[0];
            phase_d = 1'b0;
            state_d = (byte_in[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          bit_cnt_d = '0;
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
            rd_load  = (rw_q == I2C_RW_READ);
          end else if (rw_q == I2C_RW_WRITE) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR_DATA;
          end else begin
            sda_oe_d = ~shift_q[7];
            state_d  = ST_RD_DATA;
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            state_d = ST_WR_ACK;
            if (!m_tvalid_q || m_axis_tready) begin
              m_tdata_d  = byte_in;
              m_tvalid_d = 1'b1;
              ack_d      = I2C_ACK;
            end else begin
              ovf_d = 1'b1;
              ack_d = I2C_NACK;
            end
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = (ack_q == I2C_ACK);
            phase_d  = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WR_DATA;
          end
        end
        ST_RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = ST_RD_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) phase_d = 1'b1;
            else state_d = ST_WAIT_STOP;
          end else if (scl_fall && phase_q) begin
            rd_load   = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_RD_DATA;
          end
        end
        default: ;
      endcase

      if (rd_load) begin
        if (s_axis_tvalid) begin
          shift_d    = s_axis_tdata;
          s_tready_d = 1'b1;
        end else begin
          shift_d = 8'hFF;
          unf_d   = 1'b1;
        end
        if (state_q == ST_RD_ACK) sda_oe_d = ~shift_d[7];
      end
    end
  end

  always_comb begin
    m_axis_tdata  = m_tdata_q;
    m_axis_tvalid = m_tvalid_q;
    m_axis_tlast  = 1'b0;
    s_axis_tready = s_tready_q;
    busy_o        = busy_q;
    ovf_o         = ovf_q;
    unf_o         = unf_q;
    sda_drv_low   = sda_oe_q;
  end

  assign i2c_sda_io = sda_drv_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Bench for axis_i2c_slave: bit-banged I2C master plus m_axis / read-data scoreboards.
module tb_axis_i2c_slave;

  localparam int Q = 20;

  logic       clk_i;
  logic       arstn_i;
  logic       scl;
  logic       tb_sda_low;
  wire        sda_bus;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       busy_o;
  logic       ovf_o;
  logic       unf_o;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

  axis_i2c_slave #(.I2C_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .i2c_scl_i     (scl),
    .i2c_sda_io    (sda_bus),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .busy_o        (busy_o),
    .ovf_o         (ovf_o),
    .unf_o         (unf_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int         cmp_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] got_m_q[$];
  int         got_idx = 0;
  int         n_tready = 0;
  int         n_unf = 0;
  int         n_ovf = 0;

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk_i) begin
    if (m_axis_tvalid && m_axis_tready) got_m_q.push_back(m_axis_tdata);
    if (s_axis_tready) n_tready++;
    if (unf_o) n_unf++;
    if (ovf_o) n_ovf++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_start();
    if (!scl) begin
      tb_sda_low = 1'b0;
      wait_clks(Q);
      scl = 1'b1;
      wait_clks(Q);
    end
    tb_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clks(Q);
    tb_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    tb_sda_low = 1'b0;
    wait_clks(2 * Q);
  endtask

  task automatic clock_bit(input logic b, output logic smp);
    wait_clks(Q);
    tb_sda_low = ~b;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    smp = sda_bus;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_bits(output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  task automatic send_ack(input logic a);
    logic s;
    clock_bit(a, s);
  endtask

  task automatic test_reset();
    arstn_i = 1'b0; scl = 1'b1; tb_sda_low = 1'b0;
    m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
    wait_clks(5);
    arstn_i = 1'b1;
    wait_clks(3);
    cmp_cnt++; if (m_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    cmp_cnt++; if (m_axis_tdata !== 8'h00) begin err_cnt++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
    cmp_cnt++; if (s_axis_tready !== 1'b0) begin err_cnt++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    cmp_cnt++; if ({ovf_o, unf_o, m_axis_tlast} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b want 000", {ovf_o, unf_o, m_axis_tlast}); end
    cmp_cnt++; if (sda_bus !== 1'b1) begin err_cnt++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] wr_bytes[3];
    logic [7:0] e;
    wr_bytes[0] = 8'hA0; wr_bytes[1] = 8'h3C; wr_bytes[2] = 8'hC3;
    m_axis_tready = 1'b1;
    bus_start();
    cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL wr_busy_start: got %b want 1", busy_o); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) exp_m_q.push_back(wr_bytes[i]);
      write_byte(wr_bytes[i], ack);
      cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL wr_ack%0d: got %b want 0", i, ack); end
    end
    bus_stop();
    cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_stop: got %b want 0", busy_o); end
    while (exp_m_q.size() != 0) begin
      e = exp_m_q.pop_front(); cmp_cnt++;
      if (got_idx >= got_m_q.size()) begin err_cnt++; $display("FAIL wr_mdata: got none want %h", e); end
      else begin
        if (got_m_q[got_idx] !== e) begin err_cnt++; $display("FAIL wr_mdata: got %h want %h", got_m_q[got_idx], e); end
        got_idx++;
      end
    end
    cmp_cnt++; if (got_m_q.size() != got_idx) begin err_cnt++; $display("FAIL wr_extra: got %0d extra want 0", got_m_q.size() - got_idx); got_idx = got_m_q.size(); end
  endtask

  task automatic test_bad_addr();
    logic ack;
    bus_start();
    write_byte(8'hA2, ack);
    cmp_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL badaddr_ack: got %b want 1", ack); end
    write_byte(8'h00, ack);
    cmp_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL badaddr_data_ack: got %b want 1", ack); end
    cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL badaddr_busy: got %b want 1", busy_o); end
    bus_stop();
    cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL badaddr_busy_stop: got %b want 0", busy_o); end
    cmp_cnt++; if (got_m_q.size() != got_idx || m_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL badaddr_maxis: got %0d bytes tvalid %b want 0 bytes tvalid 0", got_m_q.size() - got_idx, m_axis_tvalid); got_idx = got_m_q.size(); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d, e;
    int t0, u0;
    t0 = n_tready; u0 = n_unf;
    s_axis_tdata = 8'h5A; s_axis_tvalid = 1'b1; exp_rd_q.push_back(8'h5A);
    bus_start();
    write_byte(8'hA1, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    read_bits(d);
    e = exp_rd_q.pop_front();
    cmp_cnt++; if (d !== e) begin err_cnt++; $display("FAIL rd_byte0: got %h want %h", d, e); end
    s_axis_tdata = 8'h99; exp_rd_q.push_back(8'h99);
    send_ack(1'b0);
    read_bits(d);
    e = exp_rd_q.pop_front();
    cmp_cnt++; if (d !== e) begin err_cnt++; $display("FAIL rd_byte1: got %h want %h", d, e); end
    s_axis_tvalid = 1'b0;
    send_ack(1'b1);
    bus_stop();
    cmp_cnt++; if (n_tready - t0 != 2) begin err_cnt++; $display("FAIL rd_tready_pulses: got %0d want 2", n_tready - t0); end
    cmp_cnt++; if (n_unf - u0 != 0) begin err_cnt++; $display("FAIL rd_unf_pulses: got %0d want 0", n_unf - u0); end
    cmp_cnt++; if (busy_o !== 1'b0 || sda_bus !== 1'b1) begin err_cnt++; $display("FAIL rd_idle: got busy %b sda %b want busy 0 sda 1", busy_o, sda_bus); end
  endtask

  task automatic test_underflow();
    logic ack;
    logic [7:0] d, e;
    int t0, u0;
    t0 = n_tready; u0 = n_unf;
    s_axis_tvalid = 1'b0; exp_rd_q.push_back(8'hFF);
    bus_start();
    write_byte(8'hA1, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL unf_addr_ack: got %b want 0", ack); end
    read_bits(d);
    e = exp_rd_q.pop_front();
    cmp_cnt++; if (d !== e) begin err_cnt++; $display("FAIL unf_byte: got %h want %h", d, e); end
    send_ack(1'b1);
    bus_stop();
    cmp_cnt++; if (n_unf - u0 != 1) begin err_cnt++; $display("FAIL unf_pulses: got %0d want 1", n_unf - u0); end
    cmp_cnt++; if (n_tready - t0 != 0) begin err_cnt++; $display("FAIL unf_tready_pulses: got %0d want 0", n_tready - t0); end
  endtask

  task automatic test_overflow();
    logic ack;
    logic [7:0] e;
    int o0;
    o0 = n_ovf;
    m_axis_tready = 1'b0;
    bus_start();
    write_byte(8'hA0, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL ovf_addr_ack: got %b want 0", ack); end
    exp_m_q.push_back(8'h01);
    write_byte(8'h01, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL ovf_ack1: got %b want 0", ack); end
    write_byte(8'h02, ack);
    cmp_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL ovf_ack2: got %b want 1", ack); end
    write_byte(8'h03, ack);
    cmp_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL ovf_ack3: got %b want 1", ack); end
    bus_stop();
    cmp_cnt++; if (n_ovf - o0 != 2) begin err_cnt++; $display("FAIL ovf_pulses: got %0d want 2", n_ovf - o0); end
    cmp_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h01) begin err_cnt++; $display("FAIL ovf_hold: got v%b %h want v1 01", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    wait_clks(4);
    while (exp_m_q.size() != 0) begin
      e = exp_m_q.pop_front(); cmp_cnt++;
      if (got_idx >= got_m_q.size()) begin err_cnt++; $display("FAIL ovf_mdata: got none want %h", e); end
      else begin
        if (got_m_q[got_idx] !== e) begin err_cnt++; $display("FAIL ovf_mdata: got %h want %h", got_m_q[got_idx], e); end
        got_idx++;
      end
    end
    cmp_cnt++; if (got_m_q.size() != got_idx || m_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drain: got %0d extra tvalid %b want 0 extra tvalid 0", got_m_q.size() - got_idx, m_axis_tvalid); got_idx = got_m_q.size(); end
  endtask

  task automatic test_rep_start();
    logic ack;
    logic [7:0] d, e;
    m_axis_tready = 1'b1;
    s_axis_tdata = 8'h77; s_axis_tvalid = 1'b1; exp_rd_q.push_back(8'h77);
    bus_start();
    write_byte(8'hA0, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rs_waddr_ack: got %b want 0", ack); end
    exp_m_q.push_back(8'h11);
    write_byte(8'h11, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rs_wdata_ack: got %b want 0", ack); end
    bus_start();
    write_byte(8'hA1, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rs_raddr_ack: got %b want 0", ack); end
    read_bits(d);
    e = exp_rd_q.pop_front();
    cmp_cnt++; if (d !== e) begin err_cnt++; $display("FAIL rs_rbyte: got %h want %h", d, e); end
    s_axis_tvalid = 1'b0;
    send_ack(1'b1);
    bus_stop();
    while (exp_m_q.size() != 0) begin
      e = exp_m_q.pop_front(); cmp_cnt++;
      if (got_idx >= got_m_q.size()) begin err_cnt++; $display("FAIL rs_mdata: got none want %h", e); end
      else begin
        if (got_m_q[got_idx] !== e) begin err_cnt++; $display("FAIL rs_mdata: got %h want %h", got_m_q[got_idx], e); end
        got_idx++;
      end
    end
    cmp_cnt++; if (got_m_q.size() != got_idx) begin err_cnt++; $display("FAIL rs_extra: got %0d extra want 0", got_m_q.size() - got_idx); got_idx = got_m_q.size(); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b1;
    bus_start();
    write_byte(8'hA1, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL mrst_addr_ack: got %b want 0", ack); end
    wait_clks(10);
    cmp_cnt++; if (sda_bus !== 1'b0) begin err_cnt++; $display("FAIL mrst_driving: got %b want 0", sda_bus); end
    arstn_i = 1'b0;
    wait_clks(1);
    cmp_cnt++; if (sda_bus !== 1'b1) begin err_cnt++; $display("FAIL mrst_sda_release: got %b want 1", sda_bus); end
    cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_busy: got %b want 0", busy_o); end
    arstn_i = 1'b1;
    s_axis_tvalid = 1'b0;
    wait_clks(2);
    bus_stop();
    bus_start();
    write_byte(8'hA0, ack);
    cmp_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL mrst_recover_ack: got %b want 0", ack); end
    bus_stop();
    cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_recover_busy: got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_read();
    test_underflow();
    test_overflow();
    test_rep_start();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
